// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX controller among
// NUM_REQ byte producers, with multi-byte packet lock and a completion
// watchdog. All outputs except o_Busy and the debug taps are registered.
//
// Handshakes:
//   requester side - i_Req[k] is a valid that stays high with a stable byte
//   until o_Req_Ack[k] pulses for one cycle; the ack is the only "ready" the
//   requester sees, so one ack consumes exactly one byte.
//   TX side - o_Tx_Ready/o_Tx_Byte act as valid/data; i_Tx_Active accepts the
//   launch (o_Tx_Ready falls the next cycle) and i_Tx_Done marks completion.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  input  logic [NUM_REQ-1:0]         i_Req_Last,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic [NUM_REQ-1:0]         o_Grant,
  output logic                       o_Tx_Ready,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic                       o_Timeout,
  output logic                       o_Busy,
  output logic [1:0]                 dbg_state,
  output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr,
  output logic                       dbg_lock
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner_idx;
  logic               lock;
  logic               cap_last;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] cand;
  logic               owner_req;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan;
  logic               wd_expire;

  logic               do_grant;
  logic               do_complete;
  logic               do_timeout;
  logic               do_release;
  logic               go_wait;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // The requester being acked this cycle still shows its old byte on i_Req,
  // so it is masked out until it has seen the ack.
  assign eligible   = i_Req & ~o_Req_Ack;
  assign owner_mask = ONE << owner_idx;
  assign owner_req  = eligible[owner_idx];
  assign wd_expire  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign o_Busy     = (state != ST_IDLE) || lock;
  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;
  assign dbg_lock   = lock;

  // Round-robin pick: first candidate at or after rr_ptr, lock owner only while locked.
  always_comb begin
    cand      = lock ? (eligible & owner_mask) : eligible;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && cand[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // Next-state logic and the one-cycle event strobes that drive the datapath.
  always_comb begin
    state_d     = state;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_timeout  = 1'b0;
    do_release  = 1'b0;
    go_wait     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          do_grant = 1'b1;
          state_d  = ST_LAUNCH;
        end else if (lock && wd_expire) begin
          do_release = 1'b1;
        end
      end
      ST_LAUNCH: begin
        // A very fast TX may finish before we ever see it active.
        if (i_Tx_Done) begin
          do_complete = 1'b1;
          state_d     = ST_IDLE;
        end else if (wd_expire) begin
          do_timeout = 1'b1;
          state_d    = ST_IDLE;
        end else if (i_Tx_Active) begin
          go_wait = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // Done is checked first so it wins a tie with watchdog expiry.
        if (i_Tx_Done) begin
          do_complete = 1'b1;
          state_d     = ST_IDLE;
        end else if (wd_expire) begin
          do_timeout = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Datapath: capture, pointer/lock bookkeeping, watchdog counter and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      owner_idx  <= '0;
      lock       <= 1'b0;
      cap_last   <= 1'b0;
      cnt        <= '0;
      o_Req_Ack  <= '0;
      o_Grant    <= '0;
      o_Tx_Ready <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Timeout  <= 1'b0;
    end else begin
      o_Req_Ack <= '0;
      o_Timeout <= 1'b0;

      // Counter runs while a byte is in flight, or while a lock sits idle.
      if (do_grant || do_complete || do_timeout || do_release)
        cnt <= '0;
      else if ((state != ST_IDLE) || (lock && !owner_req))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;

      if (do_grant) begin
        owner_idx  <= win_idx;
        cap_last   <= i_Req_Last[win_idx];
        o_Tx_Byte  <= i_Req_Byte[{win_idx, 3'b000} +: 8];
        o_Grant    <= ONE << win_idx;
        o_Tx_Ready <= 1'b1;
      end

      if (go_wait) o_Tx_Ready <= 1'b0;

      if (do_complete) begin
        o_Req_Ack  <= ONE << owner_idx;
        o_Grant    <= '0;
        o_Tx_Ready <= 1'b0;
        if (cap_last) begin
          lock   <= 1'b0;
          rr_ptr <= wrap_inc(owner_idx);
        end else begin
          lock   <= 1'b1;
        end
      end

      if (do_timeout) begin
        o_Timeout  <= 1'b1;
        o_Tx_Ready <= 1'b0;
        o_Grant    <= '0;
        lock       <= 1'b0;
        rr_ptr     <= wrap_inc(owner_idx);
      end

      if (do_release) begin
        lock   <= 1'b0;
        rr_ptr <= wrap_inc(owner_idx);
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_controller between NUM_REQ byte producers (e.g. command responder, debug dump, status beacon).
- Arbitrates round-robin, launches one byte at a time through the TX ready/active/done handshake, and acks the requester on completion.
- Supports packet lock so multi-byte frames are never interleaved.
- Has a completion watchdog so a stuck transmitter cannot hang the system.
- Sits between requesters and the TX controller; runs on the system clock. TX status is delivered already in the clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, clk cycles allowed from launch to i_Tx_Done; also the idle time after which a lock is released.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_Req  in  NUM_REQ  per-requester byte-valid; held high until that requester's o_Req_Ack.
- i_Req_Byte  in  8*NUM_REQ  byte of requester k at [8k+7:8k].
- i_Req_Last  in  NUM_REQ  byte is last of its frame; 0 requests a lock.
- o_Req_Ack  out  NUM_REQ  one-hot, 1-cycle pulse when the requester's byte finished transmitting.
- o_Grant  out  NUM_REQ  one-hot owner of the in-flight byte; 0 in IDLE.
- o_Tx_Ready  out  1  launch request to the TX controller.
- o_Tx_Byte  out  8  captured byte to the TX controller.
- i_Tx_Active  in  1  TX controller is shifting a frame.
- i_Tx_Done  in  1  1-cycle pulse, frame complete.
- o_Timeout  out  1  1-cycle pulse, watchdog expired.
- o_Busy  out  1  state != IDLE or lock held.

Behaviour:
- Reset (sync, active-high): state=IDLE, all outputs 0, rr_ptr=0, lock=0, counter=0. Asserting reset mid-operation abandons the in-flight byte with no ack.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE, candidate set:
  - If lock=1, the candidate is the lock owner only.
  - Otherwise the candidates are all set bits of i_Req.
  - The winner is the first requesting index at or after rr_ptr, modulo NUM_REQ.
  - If there is a winner: capture its byte and its i_Req_Last, set o_Grant, clear the counter, go to LAUNCH.
- LAUNCH: o_Tx_Ready=1 and o_Tx_Byte=captured byte, registered. Latency from i_Req rising in IDLE to o_Tx_Ready=1 is 1 cycle.
  - On i_Tx_Active=1, drop o_Tx_Ready next cycle and go to WAIT_DONE.
  - If i_Tx_Done pulses while in LAUNCH (very fast TX), treat it as completion directly.
- WAIT_DONE, on i_Tx_Done:
  - Pulse o_Req_Ack[owner] for 1 cycle and clear o_Grant.
  - If captured last=1: lock=0 and rr_ptr=owner+1 (wraps to 0).
  - If captured last=0: lock=1, owner retained, rr_ptr unchanged.
  - Return to IDLE.
- Watchdog:
  - The counter increments every cycle in LAUNCH and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without done: pulse o_Timeout, set o_Tx_Ready=0, o_Grant=0, lock=0, rr_ptr=owner+1, no ack, return to IDLE.
  - If done and timeout expiry coincide, done wins: normal ack, no o_Timeout.
- Lock idle release:
  - In IDLE with lock=1 and the owner's i_Req=0, the counter increments.
  - At TIMEOUT_CYCLES-1: lock=0 and rr_ptr=owner+1, with no o_Timeout pulse.
  - The counter clears whenever the owner requests.
- Ignored inputs:
  - i_Tx_Done and i_Tx_Active in IDLE.
  - Byte/last changes after capture.
  - i_Req of non-owners while locked.
- Requester dropping i_Req before its ack is a protocol violation; the byte is still sent and acked.
- Ack precedence: o_Req_Ack and the next grant are never in the same cycle. The earliest next o_Tx_Ready is 2 cycles after done (1 to reach IDLE, 1 to launch).

Test Plan:
- Single requester: i_Req=4'b0010, byte 0x5A, last=1. Expect:
  - o_Tx_Ready=1 one cycle later with o_Tx_Byte=0x5A, o_Grant=0010.
  - After the model's active/done, o_Req_Ack=0010 for exactly 1 cycle.
  - rr_ptr advances to 2.
- Fairness: all four request continuously, last=1, one byte each. Expect grant order 0,1,2,3,0,1; no requester acked twice before the others are acked once.
- Packet lock: req0 sends 0x11,0x22,0x33 (last only on 0x33) while req1 requests throughout. Expect TX sequence 0x11,0x22,0x33 and then req1's byte; o_Busy stays high between them.
- Watchdog: TIMEOUT_CYCLES=16, TX model never asserts done. Expect:
  - o_Timeout pulses at cycle 16 after entry to LAUNCH.
  - No ack; o_Tx_Ready=0.
  - The next requester is granted afterwards.
- Boundaries:
  - i_Tx_Done on the same cycle as watchdog expiry: ack, no o_Timeout.
  - Locked owner idle for TIMEOUT_CYCLES: lock released and the other requester is granted.
- Reset mid-operation in WAIT_DONE: all outputs 0 the next cycle, lock cleared. A subsequent request from requester 0 is granted first (rr_ptr=0).
